// File: rtl/nv_sdp_rdma_arb_pkg.sv
// Shared widths, field positions and tag layout for the SDP RDMA read arbiter.
package nv_sdp_rdma_arb_pkg;

  localparam int REQ_W    = 47;
  localparam int RSP_W    = 65;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 32;
  localparam int SIZE_LSB = 32;
  localparam int SIZE_W   = 15;

  // Requester id width sized for the largest supported requester count (8).
  localparam int ID_W = 3;

  // One tag per issued request: owning engine and burst length (beats-1).
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [SIZE_W-1:0] size;
  } tag_t;

  function automatic logic [ADDR_W-1:0] req_addr(input logic [REQ_W-1:0] pd);
    return pd[ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [SIZE_W-1:0] req_size(input logic [REQ_W-1:0] pd);
    return pd[SIZE_LSB +: SIZE_W];
  endfunction

endpackage

// File: rtl/nv_sdp_rdma_arb_tag_fifo.sv
// Flop-based FIFO of outstanding request tags; responses return in request order.
module nv_sdp_rdma_arb_tag_fifo
  import nv_sdp_rdma_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output tag_t head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  tag_t             mem_q [DEPTH];
  tag_t             mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; push while full is dropped.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_rd_arb.sv
// Round-robin sharing of one SDP RDMA DMA read channel among NREQ read engines,
// with in-order response routing driven by a tag FIFO.
module nv_nvdla_sdp_rdma_rd_arb
  import nv_sdp_rdma_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic [NREQ-1:0]        eng_req_vld,
  input  logic [NREQ*REQ_W-1:0]  eng_req_pd,
  output logic [NREQ-1:0]        eng_req_rdy,
  output logic [NREQ-1:0]        eng_rsp_vld,
  output logic [RSP_W-1:0]       eng_rsp_pd,
  input  logic [NREQ-1:0]        eng_rsp_rdy,
  output logic                   dma_rd_req_vld,
  output logic [REQ_W-1:0]       dma_rd_req_pd,
  input  logic                   dma_rd_req_rdy,
  input  logic                   dma_rd_rsp_vld,
  input  logic [RSP_W-1:0]       dma_rd_rsp_pd,
  output logic                   dma_rd_rsp_rdy,
  output logic                   arb_idle,
  output logic                   arb_err
);

  logic              req_vld_q, req_vld_d;
  logic [REQ_W-1:0]  req_pd_q, req_pd_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [SIZE_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              arb_err_q, arb_err_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [REQ_W-1:0]  grant_pd;
  logic              stage_free, can_issue, accept;
  logic              head_rdy, beat_acc, last_beat;
  logic              tag_full, tag_empty, tag_push, tag_pop;
  tag_t              tag_head, push_tag;

  nv_sdp_rdma_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .full     (tag_full),
    .empty    (tag_empty),
    .head     (tag_head)
  );

  assign stage_free = ~req_vld_q | dma_rd_req_rdy;
  assign can_issue  = stage_free & ~tag_full;

  // Round-robin search starting just after the last granted engine.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!grant_vld && eng_req_vld[(int'(ptr_q) + off) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  // One-hot accept to the winner; held low while reset is asserted.
  always_comb begin
    eng_req_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      eng_req_rdy[i] = ~nvdla_core_rst & grant_vld & can_issue & (int'(grant_idx) == i);
    end
  end

  assign accept        = |eng_req_rdy;
  assign grant_pd      = eng_req_pd[int'(grant_idx)*REQ_W +: REQ_W];
  assign push_tag.id   = grant_idx;
  assign push_tag.size = req_size(grant_pd);
  assign tag_push      = accept;

  // Output stage: load on accept, otherwise drain when the DMA side takes it.
  always_comb begin
    req_vld_d = req_vld_q;
    req_pd_d  = req_pd_q;
    ptr_d     = ptr_q;
    if (accept) begin
      req_vld_d = 1'b1;
      req_pd_d  = grant_pd;
      ptr_d     = grant_idx;
    end else if (dma_rd_req_rdy) begin
      req_vld_d = 1'b0;
    end
  end

  // Route the response beat to the engine named by the head tag.
  always_comb begin
    eng_rsp_vld = '0;
    head_rdy    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(tag_head.id) == i) begin
        eng_rsp_vld[i] = ~nvdla_core_rst & dma_rd_rsp_vld & ~tag_empty;
        head_rdy       = eng_rsp_rdy[i];
      end
    end
  end

  assign dma_rd_rsp_rdy = ~nvdla_core_rst & ~tag_empty & head_rdy;
  assign beat_acc       = dma_rd_rsp_vld & dma_rd_rsp_rdy;
  assign last_beat      = (beat_cnt_q == tag_head.size);
  assign tag_pop        = beat_acc & last_beat;

  // Beat counting within the head burst and the sticky orphan-beat error.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat_acc) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + SIZE_W'(1);
    end
    arb_err_d = arb_err_q | (dma_rd_rsp_vld & tag_empty);
  end

  // Registers; reset starts the pointer at NREQ-1 so engine 0 wins first.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      req_vld_q  <= 1'b0;
      req_pd_q   <= '0;
      ptr_q      <= ID_W'(NREQ - 1);
      beat_cnt_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      req_vld_q  <= req_vld_d;
      req_pd_q   <= req_pd_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign dma_rd_req_vld = req_vld_q;
  assign dma_rd_req_pd  = req_pd_q;
  assign eng_rsp_pd     = dma_rd_rsp_pd;
  assign arb_err        = arb_err_q;
  assign arb_idle       = ~req_vld_q & tag_empty;

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_rd_arb.sv
// Scenario bench for the SDP RDMA read arbiter with request/response scoreboards.
module tb_nv_nvdla_sdp_rdma_rd_arb;

  localparam int NREQ  = 4;
  localparam int REQ_W = 47;
  localparam int RSP_W = 65;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       eng_req_vld, eng_req_rdy, eng_rsp_vld, eng_rsp_rdy;
  logic [NREQ*REQ_W-1:0] eng_req_pd;
  logic [RSP_W-1:0]      eng_rsp_pd, dma_rd_rsp_pd;
  logic                  dma_rd_req_vld, dma_rd_req_rdy, dma_rd_rsp_vld, dma_rd_rsp_rdy;
  logic                  arb_idle, arb_err;
  logic [REQ_W-1:0]      dma_rd_req_pd;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [REQ_W-1:0] exp_req_q[$];
  int               exp_rsp_q[$];

  nv_nvdla_sdp_rdma_rd_arb #(.NREQ(NREQ), .TAG_DEPTH(16)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .eng_req_vld    (eng_req_vld),
    .eng_req_pd     (eng_req_pd),
    .eng_req_rdy    (eng_req_rdy),
    .eng_rsp_vld    (eng_rsp_vld),
    .eng_rsp_pd     (eng_rsp_pd),
    .eng_rsp_rdy    (eng_rsp_rdy),
    .dma_rd_req_vld (dma_rd_req_vld),
    .dma_rd_req_pd  (dma_rd_req_pd),
    .dma_rd_req_rdy (dma_rd_req_rdy),
    .dma_rd_rsp_vld (dma_rd_rsp_vld),
    .dma_rd_rsp_pd  (dma_rd_rsp_pd),
    .dma_rd_rsp_rdy (dma_rd_rsp_rdy),
    .arb_idle       (arb_idle),
    .arb_err        (arb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] make_pd(input logic [31:0] addr, input logic [14:0] size);
    return {size, addr};
  endfunction

  function automatic logic [RSP_W-1:0] rand_data();
    return RSP_W'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    eng_req_vld    = '0;
    eng_req_pd     = '0;
    eng_rsp_rdy    = '1;
    dma_rd_req_rdy = 1'b0;
    dma_rd_rsp_vld = 1'b0;
    dma_rd_rsp_pd  = '0;
  endtask

  task automatic set_eng(input int i, input logic [REQ_W-1:0] pd);
    eng_req_vld[i]                = 1'b1;
    eng_req_pd[i*REQ_W +: REQ_W]  = pd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_req_q.delete();
    exp_rsp_q.delete();
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    check_cnt++; if (dma_rd_req_vld !== 1'b0) $display("[TB] FAIL reset_req_vld: got %b want 0", dma_rd_req_vld); else pass_cnt++;
    check_cnt++; if (dma_rd_req_pd !== '0) $display("[TB] FAIL reset_req_pd: got %h want 0", dma_rd_req_pd); else pass_cnt++;
    check_cnt++; if (eng_req_rdy !== '0) $display("[TB] FAIL reset_eng_req_rdy: got %b want 0", eng_req_rdy); else pass_cnt++;
    check_cnt++; if (eng_rsp_vld !== '0) $display("[TB] FAIL reset_eng_rsp_vld: got %b want 0", eng_rsp_vld); else pass_cnt++;
    check_cnt++; if (dma_rd_rsp_rdy !== 1'b0) $display("[TB] FAIL reset_rsp_rdy: got %b want 0", dma_rd_rsp_rdy); else pass_cnt++;
    check_cnt++; if (arb_err !== 1'b0) $display("[TB] FAIL reset_arb_err: got %b want 0", arb_err); else pass_cnt++;
    check_cnt++; if (arb_idle !== 1'b1) $display("[TB] FAIL reset_arb_idle: got %b want 1", arb_idle); else pass_cnt++;
    rst = 1'b0;
    exp_req_q.delete();
    exp_rsp_q.delete();
  endtask

  task automatic test_single();
    logic [REQ_W-1:0] pd, exp_pd;
    logic [NREQ-1:0]  exp_v;
    int               e;
    quiet();
    pd = make_pd(32'h1000, 15'd3);
    set_eng(1, pd);
    #1;
    check_cnt++; if (eng_req_rdy !== 4'b0010) $display("[TB] FAIL single_grant: got %b want 0010", eng_req_rdy); else pass_cnt++;
    exp_req_q.push_back(pd);
    for (int b = 0; b < 4; b++) exp_rsp_q.push_back(1);
    tick();
    eng_req_vld = '0;
    #1;
    exp_pd = exp_req_q.pop_front();
    check_cnt++; if (dma_rd_req_vld !== 1'b1) $display("[TB] FAIL single_req_vld: got %b want 1", dma_rd_req_vld); else pass_cnt++;
    check_cnt++; if (dma_rd_req_pd !== exp_pd) $display("[TB] FAIL single_req_pd: got %h want %h", dma_rd_req_pd, exp_pd); else pass_cnt++;
    dma_rd_req_rdy = 1'b1;
    tick();
    check_cnt++; if (dma_rd_req_vld !== 1'b0) $display("[TB] FAIL single_req_drop: got %b want 0", dma_rd_req_vld); else pass_cnt++;
    check_cnt++; if (arb_idle !== 1'b0) $display("[TB] FAIL single_busy: got %b want 0", arb_idle); else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      dma_rd_rsp_vld = 1'b1;
      dma_rd_rsp_pd  = rand_data();
      #1;
      e = exp_rsp_q.pop_front();
      exp_v = NREQ'(1) << e;
      check_cnt++; if (eng_rsp_vld !== exp_v) $display("[TB] FAIL single_rsp_vld: beat %0d got %b want %b", b, eng_rsp_vld, exp_v); else pass_cnt++;
      check_cnt++; if (eng_rsp_pd !== dma_rd_rsp_pd) $display("[TB] FAIL single_rsp_pd: got %h want %h", eng_rsp_pd, dma_rd_rsp_pd); else pass_cnt++;
      check_cnt++; if (dma_rd_rsp_rdy !== 1'b1) $display("[TB] FAIL single_rsp_rdy: got %b want 1", dma_rd_rsp_rdy); else pass_cnt++;
      tick();
    end
    dma_rd_rsp_vld = 1'b0;
    #1;
    check_cnt++; if (arb_idle !== 1'b1) $display("[TB] FAIL single_idle_end: got %b want 1", arb_idle); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [REQ_W-1:0] pds [NREQ];
    logic [REQ_W-1:0] exp_pd;
    logic [NREQ-1:0]  exp_rdy;
    int               model_ptr, nxt;
    quiet();
    do_reset();
    dma_rd_req_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pds[i] = make_pd(32'h2000 + 32'(i) * 32'h100, 15'd0);
      set_eng(i, pds[i]);
    end
    model_ptr = NREQ - 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      nxt = (model_ptr + 1) % NREQ;
      exp_rdy = NREQ'(1) << nxt;
      check_cnt++; if (eng_req_rdy !== exp_rdy) $display("[TB] FAIL rr_grant: step %0d got %b want %b", k, eng_req_rdy, exp_rdy); else pass_cnt++;
      exp_req_q.push_back(pds[nxt]);
      model_ptr = nxt;
      tick();
      exp_pd = exp_req_q.pop_front();
      check_cnt++; if (dma_rd_req_vld !== 1'b1) $display("[TB] FAIL rr_req_vld: step %0d got %b want 1", k, dma_rd_req_vld); else pass_cnt++;
      check_cnt++; if (dma_rd_req_pd !== exp_pd) $display("[TB] FAIL rr_req_pd: step %0d got %h want %h", k, dma_rd_req_pd, exp_pd); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [REQ_W-1:0] pd0, pd2;
    quiet();
    do_reset();
    pd0 = make_pd(32'h3000, 15'd1);
    pd2 = make_pd(32'h3200, 15'd2);
    set_eng(0, pd0);
    set_eng(2, pd2);
    #1;
    check_cnt++; if (eng_req_rdy !== 4'b0001) $display("[TB] FAIL stall_first: got %b want 0001", eng_req_rdy); else pass_cnt++;
    tick();
    for (int c = 0; c < 5; c++) begin
      check_cnt++; if (eng_req_rdy !== 4'b0000) $display("[TB] FAIL stall_no_rdy: cycle %0d got %b want 0000", c, eng_req_rdy); else pass_cnt++;
      check_cnt++; if (dma_rd_req_vld !== 1'b1) $display("[TB] FAIL stall_vld: cycle %0d got %b want 1", c, dma_rd_req_vld); else pass_cnt++;
      check_cnt++; if (dma_rd_req_pd !== pd0) $display("[TB] FAIL stall_pd: cycle %0d got %h want %h", c, dma_rd_req_pd, pd0); else pass_cnt++;
      tick();
    end
    dma_rd_req_rdy = 1'b1;
    #1;
    check_cnt++; if (eng_req_rdy !== 4'b0100) $display("[TB] FAIL stall_ptr_kept: got %b want 0100", eng_req_rdy); else pass_cnt++;
    tick();
    check_cnt++; if (dma_rd_req_pd !== pd2) $display("[TB] FAIL stall_next_pd: got %h want %h", dma_rd_req_pd, pd2); else pass_cnt++;
  endtask

  task automatic test_tag_full();
    logic [NREQ-1:0] exp_v;
    int              e;
    quiet();
    do_reset();
    dma_rd_req_rdy = 1'b1;
    set_eng(3, make_pd(32'h4000, 15'd1));
    for (int k = 0; k < 16; k++) begin
      #1;
      check_cnt++; if (eng_req_rdy !== 4'b1000) $display("[TB] FAIL full_fill: req %0d got %b want 1000", k, eng_req_rdy); else pass_cnt++;
      exp_rsp_q.push_back(3);
      exp_rsp_q.push_back(3);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      check_cnt++; if (eng_req_rdy !== 4'b0000) $display("[TB] FAIL full_block: cycle %0d got %b want 0000", k, eng_req_rdy); else pass_cnt++;
      tick();
    end
    dma_rd_rsp_vld = 1'b1;
    for (int b = 0; b < 2; b++) begin
      dma_rd_rsp_pd = rand_data();
      #1;
      check_cnt++; if (eng_req_rdy !== 4'b0000) $display("[TB] FAIL full_during_rsp: beat %0d got %b want 0000", b, eng_req_rdy); else pass_cnt++;
      e = exp_rsp_q.pop_front();
      exp_v = NREQ'(1) << e;
      check_cnt++; if (eng_rsp_vld !== exp_v) $display("[TB] FAIL full_rsp_vld: beat %0d got %b want %b", b, eng_rsp_vld, exp_v); else pass_cnt++;
      tick();
    end
    dma_rd_rsp_vld = 1'b0;
    #1;
    check_cnt++; if (eng_req_rdy !== 4'b1000) $display("[TB] FAIL full_reopen: got %b want 1000", eng_req_rdy); else pass_cnt++;
    tick();
  endtask

  task automatic test_rsp_order();
    logic [NREQ-1:0] exp_v;
    int              e;
    quiet();
    do_reset();
    dma_rd_req_rdy = 1'b1;
    set_eng(0, make_pd(32'h5000, 15'd1));
    set_eng(2, make_pd(32'h5200, 15'd2));
    #1;
    check_cnt++; if (eng_req_rdy !== 4'b0001) $display("[TB] FAIL order_grant0: got %b want 0001", eng_req_rdy); else pass_cnt++;
    exp_rsp_q.push_back(0);
    exp_rsp_q.push_back(0);
    tick();
    eng_req_vld[0] = 1'b0;
    #1;
    check_cnt++; if (eng_req_rdy !== 4'b0100) $display("[TB] FAIL order_grant2: got %b want 0100", eng_req_rdy); else pass_cnt++;
    for (int b = 0; b < 3; b++) exp_rsp_q.push_back(2);
    tick();
    eng_req_vld    = '0;
    dma_rd_rsp_vld = 1'b1;
    eng_rsp_rdy    = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      dma_rd_rsp_pd = rand_data();
      #1;
      check_cnt++; if (dma_rd_rsp_rdy !== 1'b0) $display("[TB] FAIL order_stall_rdy: cycle %0d got %b want 0", c, dma_rd_rsp_rdy); else pass_cnt++;
      check_cnt++; if (eng_rsp_vld !== 4'b0001) $display("[TB] FAIL order_stall_vld: cycle %0d got %b want 0001", c, eng_rsp_vld); else pass_cnt++;
      tick();
    end
    eng_rsp_rdy = '1;
    for (int b = 0; b < 5; b++) begin
      dma_rd_rsp_pd = rand_data();
      #1;
      e = exp_rsp_q.pop_front();
      exp_v = NREQ'(1) << e;
      check_cnt++; if (eng_rsp_vld !== exp_v) $display("[TB] FAIL order_rsp_vld: beat %0d got %b want %b", b, eng_rsp_vld, exp_v); else pass_cnt++;
      check_cnt++; if (dma_rd_rsp_rdy !== 1'b1) $display("[TB] FAIL order_rsp_rdy: beat %0d got %b want 1", b, dma_rd_rsp_rdy); else pass_cnt++;
      check_cnt++; if (eng_rsp_pd !== dma_rd_rsp_pd) $display("[TB] FAIL order_rsp_pd: beat %0d got %h want %h", b, eng_rsp_pd, dma_rd_rsp_pd); else pass_cnt++;
      tick();
    end
    dma_rd_rsp_vld = 1'b0;
    #1;
    check_cnt++; if (arb_idle !== 1'b1) $display("[TB] FAIL order_idle: got %b want 1", arb_idle); else pass_cnt++;
    check_cnt++; if (arb_err !== 1'b0) $display("[TB] FAIL order_no_err: got %b want 0", arb_err); else pass_cnt++;
  endtask

  task automatic test_err_reset();
    quiet();
    do_reset();
    dma_rd_rsp_vld = 1'b1;
    dma_rd_rsp_pd  = rand_data();
    #1;
    check_cnt++; if (dma_rd_rsp_rdy !== 1'b0) $display("[TB] FAIL err_rsp_rdy: got %b want 0", dma_rd_rsp_rdy); else pass_cnt++;
    check_cnt++; if (eng_rsp_vld !== 4'b0000) $display("[TB] FAIL err_rsp_vld: got %b want 0000", eng_rsp_vld); else pass_cnt++;
    tick();
    dma_rd_rsp_vld = 1'b0;
    check_cnt++; if (arb_err !== 1'b1) $display("[TB] FAIL err_set: got %b want 1", arb_err); else pass_cnt++;
    tick();
    check_cnt++; if (arb_err !== 1'b1) $display("[TB] FAIL err_sticky: got %b want 1", arb_err); else pass_cnt++;
    dma_rd_req_rdy = 1'b1;
    set_eng(1, make_pd(32'h6000, 15'd3));
    tick();
    eng_req_vld = '0;
    tick();
    dma_rd_rsp_vld = 1'b1;
    #1;
    check_cnt++; if (eng_rsp_vld !== 4'b0010) $display("[TB] FAIL burst_rsp_vld: got %b want 0010", eng_rsp_vld); else pass_cnt++;
    tick();
    tick();
    eng_req_vld    = '1;
    dma_rd_req_rdy = 1'b0;
    rst = 1'b1;
    tick();
    check_cnt++; if (dma_rd_req_vld !== 1'b0) $display("[TB] FAIL midrst_req_vld: got %b want 0", dma_rd_req_vld); else pass_cnt++;
    check_cnt++; if (dma_rd_req_pd !== '0) $display("[TB] FAIL midrst_req_pd: got %h want 0", dma_rd_req_pd); else pass_cnt++;
    check_cnt++; if (eng_req_rdy !== 4'b0000) $display("[TB] FAIL midrst_eng_req_rdy: got %b want 0000", eng_req_rdy); else pass_cnt++;
    check_cnt++; if (eng_rsp_vld !== 4'b0000) $display("[TB] FAIL midrst_eng_rsp_vld: got %b want 0000", eng_rsp_vld); else pass_cnt++;
    check_cnt++; if (dma_rd_rsp_rdy !== 1'b0) $display("[TB] FAIL midrst_rsp_rdy: got %b want 0", dma_rd_rsp_rdy); else pass_cnt++;
    check_cnt++; if (arb_err !== 1'b0) $display("[TB] FAIL midrst_arb_err: got %b want 0", arb_err); else pass_cnt++;
    check_cnt++; if (arb_idle !== 1'b1) $display("[TB] FAIL midrst_arb_idle: got %b want 1", arb_idle); else pass_cnt++;
    rst = 1'b0;
    quiet();
    tick();
  endtask

  initial begin
    quiet();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_tag_full();
    test_rsp_order();
    test_err_reset();
    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
